// File: rtl/maxnet_param.sv
// N-channel Maxnet winner-take-all engine: iterates lateral inhibition until at most one channel survives.
// Optional build macro MAXNET_SAT_EN: saturating activation clip (default wrap-around truncation).
module maxnet_param #(
  parameter int N        = 4,
  parameter int W        = 5,
  parameter int FRAC     = 3,
  parameter int MAX_ITER = 15,
  parameter int IW       = 4,
  parameter int XW       = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] x_in,
  input  logic [W-1:0]   w_self,
  input  logic [W-1:0]   w_inh,
  output logic           busy,
  output logic           done,
  output logic           valid,
  output logic           timeout,
  output logic [XW-1:0]  winner,
  output logic [W-1:0]   max,
  output logic [IW-1:0]  iters
);

  localparam int TW = 2*W + XW + 2;
  localparam int SW = W + XW;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_ITER, ST_DONE} state_t;

  state_t state, state_nxt;

  logic [W-1:0]  a [N];
  logic [W-1:0]  c [N];
  logic [W-1:0]  ws_r, wi_r;
  logic [IW-1:0] cnt;

  logic [XW:0]   nz;
  logic [XW-1:0] idx;
  logic [SW-1:0] s;
  logic signed [TW-1:0] t [N];
  logic signed [TW-1:0] u [N];
  logic [W-1:0]  a_nxt [N];

  assign busy = (state != ST_IDLE);

  // Nonzero count, surviving index and the parallel inhibition update
  always_comb begin
    nz  = '0;
    idx = '0;
    s   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s = s + SW'(a[i]);
      if (a[i] != '0) begin
        nz  = nz + (XW+1)'(1);
        idx = XW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      t[i] = TW'(signed'(ws_r)) * signed'(TW'(a[i]))
           + TW'(signed'(wi_r)) * signed'(TW'(s - SW'(a[i])));
      u[i] = t[i] >>> FRAC;
      if (u[i] <= 0) begin
        a_nxt[i] = '0;
      end else begin
`ifdef MAXNET_SAT_EN
        a_nxt[i] = (|u[i][TW-1:W]) ? '1 : u[i][W-1:0];
`else
        a_nxt[i] = u[i][W-1:0];
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (nz <= (XW+1)'(1))           state_nxt = ST_DONE;
        else if (cnt == IW'(MAX_ITER))  state_nxt = ST_DONE;
        else                            state_nxt = ST_ITER;
      end
      ST_ITER:  state_nxt = ST_CHECK;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      for (int unsigned i = 0; i < N; i++) begin
        a[i] <= '0;
        c[i] <= '0;
      end
      ws_r    <= '0;
      wi_r    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      winner  <= '0;
      max     <= '0;
      iters   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < N; i++) begin
              a[i] <= x_in[i*W +: W];
              c[i] <= x_in[i*W +: W];
            end
            ws_r <= w_self;
            wi_r <= w_inh;
            cnt  <= '0;
          end
        end
        ST_CHECK: begin
          // Results are captured on the edge entering DONE so they line up with the pulse
          if (state_nxt == ST_DONE) begin
            done    <= 1'b1;
            valid   <= (nz == (XW+1)'(1));
            timeout <= (nz >= (XW+1)'(2));
            winner  <= (nz == (XW+1)'(1)) ? idx : '0;
            max     <= (nz == (XW+1)'(1)) ? c[idx] : '0;
            iters   <= cnt;
          end
        end
        ST_ITER: begin
          for (int unsigned i = 0; i < N; i++) a[i] <= a_nxt[i];
          cnt <= cnt + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_param.sv
// Directed bench for maxnet_param: vector table plus reset/busy corner sequences.
module tb_maxnet_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [19:0] x_in = '0;
  logic [4:0]  w_self = '0;
  logic [4:0]  w_inh = '0;

  logic        busy_v [3];
  logic        done_v [3];
  logic        valid_v [3];
  logic        timeout_v [3];
  logic [1:0]  winner_v [3];
  logic [4:0]  max_v [3];
  logic [3:0]  iters_v [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  maxnet_param dut0 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .w_self(w_self), .w_inh(w_inh),
    .busy(busy_v[0]), .done(done_v[0]), .valid(valid_v[0]), .timeout(timeout_v[0]),
    .winner(winner_v[0]), .max(max_v[0]), .iters(iters_v[0]));

  maxnet_param #(.MAX_ITER(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .w_self(w_self), .w_inh(w_inh),
    .busy(busy_v[1]), .done(done_v[1]), .valid(valid_v[1]), .timeout(timeout_v[1]),
    .winner(winner_v[1]), .max(max_v[1]), .iters(iters_v[1]));

  maxnet_param #(.MAX_ITER(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .w_self(w_self), .w_inh(w_inh),
    .busy(busy_v[2]), .done(done_v[2]), .valid(valid_v[2]), .timeout(timeout_v[2]),
    .winner(winner_v[2]), .max(max_v[2]), .iters(iters_v[2]));

  typedef struct {
    logic [19:0] x;
    logic [4:0]  ws;
    logic [4:0]  wi;
    int          sel;
    int          v, w, m, to, it;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [19:0] pack4(input int x0, input int x1, input int x2, input int x3);
    logic [4:0] b0, b1, b2, b3;
    b0 = 5'(x0); b1 = 5'(x1); b2 = 5'(x2); b3 = 5'(x3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic vec_t mk(input logic [19:0] x, input logic [4:0] ws, input logic [4:0] wi,
                              input int sel, input int v, input int w, input int m,
                              input int to, input int it);
    vec_t r;
    r.x = x; r.ws = ws; r.wi = wi; r.sel = sel;
    r.v = v; r.w = w; r.m = m; r.to = to; r.it = it;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int sel);
    chk({tag, ".busy"},    int'(busy_v[sel]),    0);
    chk({tag, ".done"},    int'(done_v[sel]),    0);
    chk({tag, ".valid"},   int'(valid_v[sel]),   0);
    chk({tag, ".timeout"}, int'(timeout_v[sel]), 0);
    chk({tag, ".winner"},  int'(winner_v[sel]),  0);
    chk({tag, ".max"},     int'(max_v[sel]),     0);
    chk({tag, ".iters"},   int'(iters_v[sel]),   0);
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while ((busy_v[0] || busy_v[1] || busy_v[2]) && g < 300) begin
      @(posedge clk); #1; g++;
    end
    chk({tag, ".idle_bound"}, int'(g >= 300), 0);
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    x_in = v.x; w_self = v.ws; w_inh = v.wi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input vec_t v);
    int cnt;
    cnt = 0;
    while (!done_v[v.sel] && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    chk({tag, ".latency"}, cnt, 2*v.it + 1);
    chk({tag, ".valid"},   int'(valid_v[v.sel]),   v.v);
    chk({tag, ".winner"},  int'(winner_v[v.sel]),  v.w);
    chk({tag, ".max"},     int'(max_v[v.sel]),     v.m);
    chk({tag, ".timeout"}, int'(timeout_v[v.sel]), v.to);
    chk({tag, ".iters"},   int'(iters_v[v.sel]),   v.it);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, int'(done_v[v.sel]), 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    pulse_start(v);
    wait_done(tag, v);
    wait_idle(tag);
  endtask

  initial begin
    int exp_a1;
`ifdef MAXNET_SAT_EN
    exp_a1 = 31;
`else
    exp_a1 = 26;
`endif
    vecs[0] = mk(pack4(2, 4, 8, 20), 5'b01000, 5'b11110, 0, 1, 3, 20, 0, 2);
    vecs[1] = mk(pack4(8, 8, 0, 0),  5'b01000, 5'b11110, 0, 0, 0, 0,  0, 6);
    vecs[2] = mk(pack4(8, 8, 0, 0),  5'b01000, 5'b11110, 1, 0, 0, 0,  1, 4);
    vecs[3] = mk(pack4(0, 0, 0, 0),  5'b01000, 5'b11110, 0, 0, 0, 0,  0, 0);
    vecs[4] = mk(pack4(0, 9, 0, 0),  5'b01000, 5'b11110, 0, 1, 1, 9,  0, 0);
    vecs[5] = mk(pack4(31, 0, 0, 0), 5'b01111, 5'b00000, 0, 1, 0, 31, 0, 0);
    vecs[6] = mk(pack4(31, 31, 0, 0), 5'b01111, 5'b00000, 2, 0, 0, 0, 1, 1);
    vecs[7] = mk(pack4(5, 0, 0, 7),  5'b01000, 5'b11110, 0, 1, 3, 7,  0, 3);

    // Reset state
    #12;
    for (int d = 0; d < 3; d++) chk_zero($sformatf("reset%0d", d), d);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) begin
      run_vec($sformatf("vec%0d", k), vecs[k]);
      if (k == 6) begin
        chk("vec6.a0", int'(dut2.a[0]), exp_a1);
        chk("vec6.a1", int'(dut2.a[1]), exp_a1);
      end
    end

    // Held results while busy, and start ignored mid-run
    run_vec("pre_busy", vecs[0]);
    pulse_start(vecs[1]);
    @(posedge clk); #1;
    chk("busy.busy",   int'(busy_v[0]),   1);
    chk("busy.held_v", int'(valid_v[0]),  1);
    chk("busy.held_w", int'(winner_v[0]), 3);
    chk("busy.held_m", int'(max_v[0]),    20);
    @(negedge clk);
    x_in = pack4(0, 9, 0, 0); w_self = 5'b01111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int cnt;
      cnt = 2;
      while (!done_v[0] && cnt < 200) begin
        @(posedge clk); #1; cnt++;
      end
      chk("ignore.latency", cnt, 13);
      chk("ignore.valid",   int'(valid_v[0]),   0);
      chk("ignore.iters",   int'(iters_v[0]),   6);
      chk("ignore.timeout", int'(timeout_v[0]), 0);
    end
    wait_idle("ignore");

    // Asynchronous reset in the middle of an ITER cycle
    run_vec("pre_rst", vecs[0]);
    pulse_start(vecs[0]);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midrst", 0);
    @(negedge clk);
    rst = 1'b1;
    run_vec("post_rst", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
